// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_loader
// Brief    : Packs decoded Op/I/L instruction fields into 32-bit words and
//            writes them sequentially into instruction memory.
// Revision : 1.0 - initial release
// ============================================================================
module instr_loader #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64,
    parameter int BASE   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        cond,
    input  logic [1:0]        op,
    input  logic              i_bit,
    input  logic              l_bit,
    input  logic [3:0]        cmd,
    input  logic              s_bit,
    input  logic [3:0]        rn,
    input  logic [3:0]        rd,
    input  logic [11:0]       src2,
    input  logic [23:0]       imm24,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              full,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       word_q, word_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;
    logic              fin_q, fin_d;

    logic [31:0]       enc_word;
    logic              op_legal;
    logic              handshake;

    // Field packing; memory ops are always pre-indexed, up, word, no write-back.
    always_comb begin
        enc_word = 32'h0;
        case (op)
            2'b00:   enc_word = {cond, 2'b00, i_bit, cmd, s_bit, rn, rd, src2};
            2'b01:   enc_word = {cond, 2'b01, i_bit, 1'b1, 1'b1, 1'b0, 1'b0,
                                 l_bit, rn, rd, src2};
            2'b10:   enc_word = {cond, 2'b10, 2'b10, imm24};
            default: enc_word = 32'h0;
        endcase
    end

    assign op_legal   = (op != 2'b11);
    assign full       = (count_q == DEPTH_C);
    assign in_ready   = (state_q == S_ACCEPT) && !full;
    assign handshake  = in_valid && in_ready;

    assign mem_we     = (state_q == S_WRITE);
    assign mem_addr   = BASE_C + count_q[ADDR_W-1:0];
    assign mem_wdata  = mem_we ? word_q : 32'h0;
    assign word_count = count_q;
    assign busy       = (state_q == S_ACCEPT) || (state_q == S_WRITE);
    assign done       = (state_q == S_DONE);
    assign err        = err_q;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        count_d = count_q;
        err_d   = err_q;
        fin_d   = fin_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ACCEPT;
                    count_d = '0;
                    err_d   = 1'b0;
                    fin_d   = 1'b0;
                end
            end
            S_ACCEPT: begin
                if (start) begin
                    count_d = '0;
                    err_d   = 1'b0;
                    fin_d   = 1'b0;
                end
                // A bundle accepted alongside start becomes the first word of the new load.
                if (handshake) begin
                    if (op_legal) begin
                        word_d  = enc_word;
                        state_d = S_WRITE;
                        fin_d   = finish && !start;
                    end else begin
                        err_d = 1'b1;
                        if (finish && !start) begin
                            state_d = S_DONE;
                        end
                    end
                end else if (finish && !start) begin
                    state_d = S_DONE;
                end
            end
            S_WRITE: begin
                count_d = count_q + 1'b1;
                fin_d   = 1'b0;
                if (start) begin
                    state_d = S_ACCEPT;
                    count_d = '0;
                    err_d   = 1'b0;
                end else if (fin_q || finish) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ACCEPT;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_ACCEPT;
                    count_d = '0;
                    err_d   = 1'b0;
                    fin_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            word_q  <= 32'h0;
            count_q <= '0;
            err_q   <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            count_q <= count_d;
            err_q   <= err_d;
            fin_q   <= fin_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_loader
// Brief    : Directed self-checking bench for instr_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_loader;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    logic              clk = 1'b0;
    logic              rst, start, finish, in_valid, in_ready;
    logic [3:0]        cond, cmd, rn, rd;
    logic [1:0]        op;
    logic              i_bit, l_bit, s_bit;
    logic [11:0]       src2;
    logic [23:0]       imm24;
    logic              mem_we, busy, full, done, err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   word_count;

    int checks = 0;
    int errors = 0;
    int n_writes;

    always #5 clk = ~clk;

    instr_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE(0)) dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready),
        .cond(cond), .op(op), .i_bit(i_bit), .l_bit(l_bit), .cmd(cmd),
        .s_bit(s_bit), .rn(rn), .rd(rd), .src2(src2), .imm24(imm24),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .word_count(word_count), .busy(busy), .full(full), .done(done),
        .err(err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_fields(input logic [3:0] c, input logic [1:0] o, input logic ib,
                              input logic lb, input logic [3:0] cm, input logic sb,
                              input logic [3:0] n, input logic [3:0] d,
                              input logic [11:0] s2, input logic [23:0] im);
        cond = c; op = o; i_bit = ib; l_bit = lb; cmd = cm; s_bit = sb;
        rn = n; rd = d; src2 = s2; imm24 = im;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one bundle for one cycle; returns positioned just after the handshake edge.
    task automatic send();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        set_fields(4'h0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 12'h0, 24'h0);
        tick(); tick();
        rst = 1'b0;

        check("rst_in_ready", in_ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_count", word_count, 0);
        check("rst_busy_full_done_err", {busy, full, done, err}, 0);

        // finish in IDLE is ignored
        finish = 1'b1; tick(); finish = 1'b0;
        check("idle_finish_done", done, 0);

        // Data-processing word
        pulse_start();
        check("accept_busy", busy, 1);
        check("accept_ready", in_ready, 1);
        set_fields(4'hE, 2'b00, 1'b1, 1'b0, 4'h4, 1'b0, 4'h2, 4'h1, 12'h005, 24'h0);
        send();
        check("dp_we", mem_we, 1);
        check("dp_addr", mem_addr, 0);
        check("dp_wdata", mem_wdata, 32'hE2821005);
        check("dp_ready_in_write", in_ready, 0);
        tick();
        check("dp_count", word_count, 1);
        check("dp_we_after", mem_we, 0);
        check("dp_wdata_zero", mem_wdata, 0);

        // Memory then branch from a fresh load
        pulse_start();
        check("restart_count", word_count, 0);
        set_fields(4'hE, 2'b01, 1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 4'h3, 12'h008, 24'h0);
        send();
        check("mem_addr0", mem_addr, 0);
        check("mem_wdata0", mem_wdata, 32'hE5903008);
        check("mem_ready_in_write", in_ready, 0);
        tick();
        set_fields(4'hE, 2'b10, 1'b1, 1'b1, 4'hF, 1'b1, 4'hF, 4'hF, 12'hFFF, 24'hFFFFFE);
        send();
        check("br_addr1", mem_addr, 1);
        check("br_wdata1", mem_wdata, 32'hEAFFFFFE);
        check("br_ready_in_write", in_ready, 0);
        tick();
        check("br_count", word_count, 2);

        // Illegal op between two legal bundles
        pulse_start();
        set_fields(4'hE, 2'b00, 1'b1, 1'b0, 4'h4, 1'b0, 4'h2, 4'h1, 12'h005, 24'h0);
        send();
        check("ill_first_addr", mem_addr, 0);
        tick();
        set_fields(4'hE, 2'b11, 1'b1, 1'b1, 4'hF, 1'b1, 4'h1, 4'h1, 12'h123, 24'h0);
        send();
        check("ill_no_we", mem_we, 0);
        check("ill_err", err, 1);
        check("ill_ready", in_ready, 1);
        check("ill_count", word_count, 1);
        set_fields(4'hE, 2'b01, 1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 4'h3, 12'h008, 24'h0);
        send();
        check("ill_second_addr", mem_addr, 1);
        check("ill_second_wdata", mem_wdata, 32'hE5903008);
        tick();
        check("ill_final_count", word_count, 2);
        check("ill_err_sticky", err, 1);

        // Fill to DEPTH with in_valid held high
        pulse_start();
        check("fill_err_cleared", err, 0);
        set_fields(4'h0, 2'b00, 1'b0, 1'b0, 4'hD, 1'b0, 4'h0, 4'h5, 12'h0AA, 24'h0);
        n_writes = 0;
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 2 * (DEPTH + 2); cyc++) begin
            tick();
            if (mem_we) begin
                check("fill_addr", mem_addr, n_writes[ADDR_W-1:0]);
                n_writes++;
            end
        end
        in_valid = 1'b0;
        check("fill_writes", n_writes, DEPTH);
        check("fill_count", word_count, DEPTH);
        check("fill_full", full, 1);
        check("fill_ready", in_ready, 0);
        finish = 1'b1; tick(); finish = 1'b0;
        check("fill_done", done, 1);
        check("fill_done_busy", busy, 0);

        // finish coincident with a handshake
        pulse_start();
        check("fin_done_cleared", done, 0);
        check("fin_count_cleared", word_count, 0);
        set_fields(4'hE, 2'b11, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 12'h0, 24'h0);
        send();
        check("fin_err_set", err, 1);
        set_fields(4'hE, 2'b10, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 12'h0, 24'h000010);
        finish = 1'b1;
        send();
        finish = 1'b0;
        check("fin_we", mem_we, 1);
        check("fin_wdata", mem_wdata, 32'hEA000010);
        check("fin_not_done_yet", done, 0);
        tick();
        check("fin_done", done, 1);
        check("fin_count", word_count, 1);
        pulse_start();
        check("fin_restart_ready", in_ready, 1);
        check("fin_restart_count", word_count, 0);
        check("fin_restart_err", err, 0);
        check("fin_restart_done", done, 0);

        // Reset in the handshake cycle abandons the write
        set_fields(4'hE, 2'b00, 1'b1, 1'b0, 4'h4, 1'b0, 4'h2, 4'h1, 12'h005, 24'h0);
        in_valid = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        check("rst_mid_we", mem_we, 0);
        check("rst_mid_wdata", mem_wdata, 0);
        check("rst_mid_ready", in_ready, 0);
        check("rst_mid_flags", {busy, full, done, err}, 0);
        tick();
        check("rst_mid_we_later", mem_we, 0);
        check("rst_mid_count", word_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
